// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: sequences LOAD / ALU / INCDEC / SHIFT commands onto an external
//   4-bit register and ALU, repeating each command cmd_cnt+1 times.
// Latency: handshake at edge k -> EXEC k+1..k+N -> DONE k+N+1 -> IDLE.
// Backpressure: cmd_ready is high only in IDLE with clr low; offers while busy
//   are ignored.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   cmd_valid/cmd_ready        command handshake
//   cmd_kind/op/data/cnt       command fields (kind, opcode, operand, repeat)
//   clr                        synchronous abort plus register clear
//   alu_oc/alu_a/alu_b, alu_f  ALU drive and its combinational result
//   reg_cl..reg_il, reg_in     register controls and load value
//   reg_out                    register contents
//   busy, done, result         status, completion pulse, captured accumulator
module alu_seq_ctrl #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_kind,
  input  logic [2:0]       cmd_op,
  input  logic [3:0]       cmd_data,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic             clr,
  output logic [2:0]       alu_oc,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  input  logic [3:0]       alu_f,
  output logic             reg_cl,
  output logic             reg_ld,
  output logic             reg_inc,
  output logic             reg_dec,
  output logic             reg_sr,
  output logic             reg_ir,
  output logic             reg_sl,
  output logic             reg_il,
  output logic [3:0]       reg_in,
  input  logic [3:0]       reg_out,
  output logic             busy,
  output logic             done,
  output logic [3:0]       result
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_EXEC  = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [1:0] S_CLEAR = 2'd3;

  localparam logic [1:0] K_LOAD   = 2'd0;
  localparam logic [1:0] K_ALU    = 2'd1;
  localparam logic [1:0] K_INCDEC = 2'd2;
  localparam logic [1:0] K_SHIFT  = 2'd3;

  logic [1:0]       state;
  logic [1:0]       kind_q;
  logic [2:0]       op_q;
  logic [3:0]       data_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       result_q;

  // Sequencing state. clr overrides every state, including a pending offer
  // in IDLE, so no command is latched while it is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      kind_q   <= '0;
      op_q     <= '0;
      data_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else if (clr) begin
      state <= S_CLEAR;
      cnt_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            kind_q <= cmd_kind;
            op_q   <= cmd_op;
            data_q <= cmd_data;
            // LOAD is a single write regardless of the repeat field.
            cnt_q  <= (cmd_kind == K_LOAD) ? '0 : cmd_cnt;
            state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (cnt_q == '0) begin
            state <= S_DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_DONE: begin
          // Register already holds the final iteration's value here.
          result_q <= reg_out;
          state    <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Output decode from state plus latched command.
  always_comb begin
    cmd_ready = (state == S_IDLE) && !clr;
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
    result    = (state == S_DONE) ? reg_out : result_q;
    alu_oc    = '0;
    alu_a     = '0;
    alu_b     = '0;
    reg_cl    = 1'b0;
    reg_ld    = 1'b0;
    reg_inc   = 1'b0;
    reg_dec   = 1'b0;
    reg_sr    = 1'b0;
    reg_ir    = 1'b0;
    reg_sl    = 1'b0;
    reg_il    = 1'b0;
    reg_in    = '0;

    if (state == S_CLEAR) begin
      reg_cl = 1'b1;
    end else if (state == S_EXEC) begin
      case (kind_q)
        K_LOAD: begin
          reg_ld = 1'b1;
          reg_in = data_q;
        end
        K_ALU: begin
          // Each iteration feeds the register's current value back as a.
          alu_oc = op_q;
          alu_a  = reg_out;
          alu_b  = data_q;
          reg_ld = 1'b1;
          reg_in = alu_f;
        end
        K_INCDEC: begin
          reg_inc = !op_q[0];
          reg_dec = op_q[0];
        end
        default: begin
          // Serial-in bit is only driven alongside its own shift direction.
          reg_sr = !op_q[0];
          reg_ir = !op_q[0] && op_q[1];
          reg_sl = op_q[0];
          reg_il = op_q[0] && op_q[1];
        end
      endcase
    end
  end

endmodule
